// File: rtl/fft_pkg.sv
// Shared defaults, index-width helper and per-stage delay depth for the streaming FFT.
package fft_pkg;

  localparam int unsigned BW_DEF   = 16;
  localparam int unsigned N_PT_DEF = 64;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } bf_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sdf_delay(input int unsigned n_pt, input int unsigned stage);
    return n_pt >> (stage + 1);
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated shift register used as the SDF feedback memory; contents are not reset.
module sdf_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage with twiddle index output.
module sdf_bf_stage import fft_pkg::*; #(
  parameter int unsigned BW      = BW_DEF,
  parameter int unsigned N_pt    = N_PT_DEF,
  parameter int unsigned STAGE   = 0,
  parameter int unsigned cnt_num = idx_width(N_pt)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [BW-1:0]  in_Real,
  input  logic signed [BW-1:0]  in_Imag,
  output logic                  out_valid,
  output logic signed [BW-1:0]  out_Real,
  output logic signed [BW-1:0]  out_Imag,
  output logic [cnt_num-1:0]    out_cnt
);

  localparam int unsigned D  = sdf_delay(N_pt, STAGE);
  localparam int unsigned KW = $clog2(2 * D);
  localparam int unsigned DW = 2 * BW;

  logic [KW-1:0]        k;
  bf_state_t            state;
  logic                 phase_b;
  logic                 k_wrap;
  logic [DW-1:0]        head;
  logic [DW-1:0]        dl_in;
  logic                 dl_en;
  logic signed [BW-1:0] a_re, a_im;
  logic signed [BW:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [BW-1:0] sum_re_h, sum_im_h, dif_re_h, dif_im_h;
  logic [cnt_num-1:0]   cnt_c;

  assign phase_b = (k >= KW'(D));
  assign k_wrap  = (k == KW'(2 * D - 1));
  assign {a_re, a_im} = head;

  // Widen by one bit so the sum/difference never overflows, then floor-halve.
  always_comb begin
    sum_re   = (BW+1)'(a_re) + (BW+1)'(in_Real);
    sum_im   = (BW+1)'(a_im) + (BW+1)'(in_Imag);
    dif_re   = (BW+1)'(a_re) - (BW+1)'(in_Real);
    dif_im   = (BW+1)'(a_im) - (BW+1)'(in_Imag);
    sum_re_h = BW'(sum_re >>> 1);
    sum_im_h = BW'(sum_im >>> 1);
    dif_re_h = BW'(dif_re >>> 1);
    dif_im_h = BW'(dif_im >>> 1);
  end

  assign cnt_c = (cnt_num'(k) & cnt_num'(D - 1)) << STAGE;

  // Phase A stores raw input; phase B stores the half-difference for the next frame.
  assign dl_en = in_valid & ~rst;
  assign dl_in = phase_b ? {dif_re_h, dif_im_h} : {in_Real, in_Imag};

  sdf_delay_line #(
    .DEPTH (D),
    .WIDTH (DW)
  ) u_delay (
    .clk  (clk),
    .en   (dl_en),
    .din  (dl_in),
    .dout (head)
  );

  // Counter, FILL/RUN state and output registers; data holds whenever no valid output is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      state     <= ST_FILL;
      out_valid <= 1'b0;
      out_Real  <= '0;
      out_Imag  <= '0;
      out_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        k <= k_wrap ? '0 : k + KW'(1);
        if (phase_b) begin
          state     <= ST_RUN;
          out_valid <= 1'b1;
          out_Real  <= sum_re_h;
          out_Imag  <= sum_im_h;
          out_cnt   <= '0;
        end else if (state == ST_RUN) begin
          out_valid <= 1'b1;
          out_Real  <= a_re;
          out_Imag  <= a_im;
          out_cnt   <= cnt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Scoreboard bench for sdf_bf_stage at STAGE 5 (D=1), STAGE 0 (D=32) and STAGE 1 (D=16).
module tb_sdf_bf_stage;

  typedef struct {
    int re;
    int im;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;

  logic               v_a, v_b, v_c;
  logic signed [15:0] re_a, re_b, re_c, im_a, im_b, im_c;
  logic [5:0]         cnt_a, cnt_b, cnt_c;

  int sel = 0;
  logic               sel_valid;
  logic signed [31:0] sel_re, sel_im;
  logic [31:0]        sel_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  logic use_model = 1'b0;
  exp_t exp_q[$];
  int   hist_re[$];
  int   hist_im[$];

  always #5 clk = ~clk;

  sdf_bf_stage #(.BW(16), .N_pt(64), .STAGE(5), .cnt_num(6)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_Real(in_re), .in_Imag(in_im),
    .out_valid(v_a), .out_Real(re_a), .out_Imag(im_a), .out_cnt(cnt_a));

  sdf_bf_stage #(.BW(16), .N_pt(64), .STAGE(0), .cnt_num(6)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_Real(in_re), .in_Imag(in_im),
    .out_valid(v_b), .out_Real(re_b), .out_Imag(im_b), .out_cnt(cnt_b));

  sdf_bf_stage #(.BW(16), .N_pt(64), .STAGE(1), .cnt_num(6)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_Real(in_re), .in_Imag(in_im),
    .out_valid(v_c), .out_Real(re_c), .out_Imag(im_c), .out_cnt(cnt_c));

  always_comb begin
    case (sel)
      0:       begin sel_valid = v_a; sel_re = 32'(re_a); sel_im = 32'(im_a); sel_cnt = 32'(cnt_a); end
      1:       begin sel_valid = v_b; sel_re = 32'(re_b); sel_im = 32'(im_b); sel_cnt = 32'(cnt_b); end
      default: begin sel_valid = v_c; sel_re = 32'(re_c); sel_im = 32'(im_c); sel_cnt = 32'(cnt_c); end
    endcase
  end

  function automatic int sel_d();
    return (sel == 0) ? 1 : (sel == 1) ? 32 : 16;
  endfunction

  function automatic int sel_stage();
    return (sel == 0) ? 5 : (sel == 1) ? 0 : 1;
  endfunction

  // Index-based reference: sample n pairs with n-D (sum) or its diff emerges one frame later.
  task automatic model_push(input int re, input int im);
    int   n, d, p;
    exp_t e;
    n = hist_re.size();
    d = sel_d();
    p = n % (2 * d);
    if (p >= d) begin
      e.re = (hist_re[n-d] + re) >>> 1;
      e.im = (hist_im[n-d] + im) >>> 1;
      e.cnt = 0;
      exp_q.push_back(e);
    end else if (n >= 2 * d) begin
      e.re = (hist_re[n-2*d] - hist_re[n-d]) >>> 1;
      e.im = (hist_im[n-2*d] - hist_im[n-d]) >>> 1;
      e.cnt = p << sel_stage();
      exp_q.push_back(e);
    end
    hist_re.push_back(re);
    hist_im.push_back(im);
  endtask

  task automatic step(input logic v, input int re, input int im);
    in_valid = v;
    in_re = 16'(re);
    in_im = 16'(im);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (v && use_model) model_push(re, im);
  endtask

  // Reset with a live sample on the bus, which must be dropped.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_re = 16'sd1234;
    in_im = -16'sd77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    hist_re.delete();
    hist_im.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_chk++;
      if (sel_valid !== 1'b0 || sel_re !== 0 || sel_im !== 0 || sel_cnt !== 0) begin
        n_err++;
        $display("FAIL reset_state dut=%0d got v=%b re=%0d im=%0d cnt=%0d want 0/0/0/0",
                 s, sel_valid, sel_re, sel_im, sel_cnt);
      end
    end
  endtask

  task automatic test_d1_basic();
    sel = 0;
    use_model = 1'b0;
    do_reset();
    step(1'b1, 100, 0);
    n_chk++;
    if (sel_valid !== 1'b0) begin
      n_err++; $display("FAIL d1_first_masked got v=%b want 0", sel_valid);
    end
    step(1'b1, 60, 0);
    n_chk++;
    if (sel_valid !== 1'b1 || sel_re !== 80 || sel_im !== 0 || sel_cnt !== 0) begin
      n_err++; $display("FAIL d1_sum got v=%b re=%0d im=%0d cnt=%0d want 1/80/0/0", sel_valid, sel_re, sel_im, sel_cnt);
    end
    step(1'b0, 5, 5);
    n_chk++;
    if (sel_valid !== 1'b0 || sel_re !== 80) begin
      n_err++; $display("FAIL d1_hold got v=%b re=%0d want 0/80", sel_valid, sel_re);
    end
    step(1'b1, 0, 0);
    n_chk++;
    if (sel_valid !== 1'b1 || sel_re !== 20 || sel_im !== 0 || sel_cnt !== 0) begin
      n_err++; $display("FAIL d1_diff got v=%b re=%0d im=%0d cnt=%0d want 1/20/0/0", sel_valid, sel_re, sel_im, sel_cnt);
    end
  endtask

  task automatic test_rounding();
    int want_re[4] = '{-2, -2, 32767, 0};
    int xs[5] = '{-3, 0, 32767, 32767, 0};
    sel = 0;
    use_model = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, xs[i], 0);
      if (i > 0) begin
        n_chk++;
        if (sel_valid !== 1'b1 || sel_re !== want_re[i-1] || sel_im !== 0 || sel_cnt !== 0) begin
          n_err++;
          $display("FAIL rounding i=%0d got v=%b re=%0d im=%0d want 1/%0d/0", i, sel_valid, sel_re, sel_im, want_re[i-1]);
        end
      end
    end
  endtask

  task automatic test_impulse();
    exp_t e;
    logic has;
    sel = 1;
    use_model = 1'b1;
    do_reset();
    for (int n = 0; n < 97; n++) begin
      step(1'b1, (n == 0) ? 1000 : 0, (n == 0) ? -1000 : 0);
      has = (exp_q.size() != 0);
      if (has) e = exp_q.pop_front();
      n_chk++;
      if (sel_valid !== has) begin
        n_err++; $display("FAIL impulse_valid n=%0d got %b want %b", n, sel_valid, has);
      end else if (has) begin
        n_chk++;
        if (sel_re !== e.re || sel_im !== e.im || sel_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL impulse_data n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, sel_re, sel_im, sel_cnt, e.re, e.im, e.cnt);
        end
      end
    end
  endtask

  task automatic test_cnt_stride();
    exp_t e;
    logic has;
    int   first = -1;
    sel = 2;
    use_model = 1'b1;
    do_reset();
    for (int n = 0; n < 96; n++) begin
      step(1'b1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      if (sel_valid === 1'b1 && first < 0) first = n;
      has = (exp_q.size() != 0);
      if (has) e = exp_q.pop_front();
      n_chk++;
      if (sel_valid !== has) begin
        n_err++; $display("FAIL stride_valid n=%0d got %b want %b", n, sel_valid, has);
      end else if (has) begin
        n_chk++;
        if (sel_re !== e.re || sel_im !== e.im || sel_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL stride_data n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, sel_re, sel_im, sel_cnt, e.re, e.im, e.cnt);
        end
      end
    end
    n_chk++;
    if (first != 16) begin
      n_err++; $display("FAIL stride_first_valid got %0d want 16", first);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic has;
    logic v;
    int   acc = 0;
    sel = 1;
    use_model = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 1000 && acc < 128; cyc++) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, (acc == 0) ? 1000 : 0, (acc == 0) ? -1000 : 0);
      if (v) acc++;
      has = (exp_q.size() != 0);
      if (has) e = exp_q.pop_front();
      n_chk++;
      if (sel_valid !== has) begin
        n_err++; $display("FAIL stall_valid cyc=%0d got %b want %b", cyc, sel_valid, has);
      end else if (has) begin
        n_chk++;
        if (sel_re !== e.re || sel_im !== e.im || sel_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL stall_data cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc, sel_re, sel_im, sel_cnt, e.re, e.im, e.cnt);
        end
      end
    end
    n_chk++;
    if (acc != 128) begin
      n_err++; $display("FAIL stall_budget accepted %0d want 128", acc);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic has;
    sel = 1;
    use_model = 1'b1;
    do_reset();
    for (int n = 0; n < 40; n++) step(1'b1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
    exp_q.delete();
    do_reset();
    n_chk++;
    if (sel_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_valid got %b want 0", sel_valid);
    end
    for (int n = 0; n < 97; n++) begin
      step(1'b1, (n == 0) ? 1000 : 0, (n == 0) ? -1000 : 0);
      has = (exp_q.size() != 0);
      if (has) e = exp_q.pop_front();
      n_chk++;
      if (sel_valid !== has) begin
        n_err++; $display("FAIL restart_valid n=%0d got %b want %b", n, sel_valid, has);
      end else if (has) begin
        n_chk++;
        if (sel_re !== e.re || sel_im !== e.im || sel_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL restart_data n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, sel_re, sel_im, sel_cnt, e.re, e.im, e.cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_d1_basic();
    test_rounding();
    test_impulse();
    test_cnt_stride();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
